// File: rtl/snake_head_mover.sv
// snake_head_mover: advances the snake head one cell per game tick, rejecting reversals and detecting wall hits
module snake_head_mover #(
  parameter int TICK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] dir,
  input  logic       start,
  output logic [3:0] head_x,
  output logic [3:0] head_y,
  output logic [1:0] heading,
  output logic       step,
  output logic       alive,
  output logic       dead
);
  localparam int CW = $clog2(TICK_CYCLES);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] x_q, x_d, y_q, y_d;
  logic [1:0] h_q, h_d, nh;
  logic step_q, step_d, alive_q, dead_q, tick, wall;
  assign tick = (state_q == RUN) && (cnt_q == CW'(TICK_CYCLES - 1));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    x_d = x_q;
    y_d = y_q;
    h_d = h_q;
    step_d = 1'b0;
    nh = h_q;
    wall = 1'b0;
    if (state_q != RUN && start) begin
      state_d = RUN;
      cnt_d = '0;
      x_d = 4'd8;
      y_d = 4'd8;
      h_d = 2'b01;
    end else if (state_q == RUN) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        nh = (dir == (h_q ^ 2'b10)) ? h_q : dir;
        wall = nh == 2'b00 ? y_q == 4'd0 : nh == 2'b01 ? x_q == 4'd15 : nh == 2'b10 ? y_q == 4'd15 : x_q == 4'd0;
        h_d = nh;
        state_d = wall ? DEAD : RUN;
        step_d = !wall;
        x_d = wall ? x_q : nh == 2'b01 ? x_q + 4'd1 : nh == 2'b11 ? x_q - 4'd1 : x_q;
        y_d = wall ? y_q : nh == 2'b10 ? y_q + 4'd1 : nh == 2'b00 ? y_q - 4'd1 : y_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      x_q <= 4'd8;
      y_q <= 4'd8;
      h_q <= 2'b01;
      step_q <= 1'b0;
      alive_q <= 1'b0;
      dead_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      h_q <= h_d;
      step_q <= step_d;
      alive_q <= state_d == RUN;
      dead_q <= state_d == DEAD;
    end
  end
  assign head_x = x_q;
  assign head_y = y_q;
  assign heading = h_q;
  assign step = step_q;
  assign alive = alive_q;
  assign dead = dead_q;
endmodule

// File: tb/tb_snake_head_mover.sv
// tb_snake_head_mover: scoreboard-driven checks of moves, reversals, walls, reset and restart
module tb_snake_head_mover;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dir = 2'b01;
  logic start = 1'b0;
  logic [3:0] head_x, head_y;
  logic [1:0] heading;
  logic step, alive, dead;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] h;
    logic s;
    logic a;
    logic d;
  } exp_t;
  exp_t sb[$];
  exp_t got, e;
  snake_head_mover #(.TICK_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .dir(dir),
    .start(start),
    .head_x(head_x),
    .head_y(head_y),
    .heading(heading),
    .step(step),
    .alive(alive),
    .dead(dead)
  );
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic compare(input string name);
    got = {head_x, head_y, heading, step, alive, dead};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d h=%0d step=%0b alive=%0b dead=%0b, expected x=%0d y=%0d h=%0d step=%0b alive=%0b dead=%0b",
               name, got.x, got.y, got.h, got.s, got.a, got.d, e.x, e.y, e.h, e.s, e.a, e.d);
    end
  endtask
  task automatic do_reset;
    reset = 1'b1;
    start = 1'b0;
    cyc();
    reset = 1'b0;
    sb.push_back({4'd8, 4'd8, 2'b01, 1'b0, 1'b0, 1'b0});
    compare("reset_values");
  endtask
  task automatic start_game;
    start = 1'b1;
    cyc();
    start = 1'b0;
    sb.push_back({4'd8, 4'd8, 2'b01, 1'b0, 1'b1, 1'b0});
    compare("start");
  endtask
  // three non-tick edges with dir churning (mid at the second one), then the tick edge with d
  task automatic do_tick(input logic [1:0] d, input logic [1:0] mid, input exp_t ex, input string name);
    for (int i = 0; i < 3; i++) begin
      dir = (i == 1) ? mid : 2'($urandom_range(0, 3));
      cyc();
      checks++;
      if (step !== 1'b0) begin
        errors++;
        $display("FAIL %s_between_ticks: step=%0b expected 0", name, step);
      end
    end
    dir = d;
    sb.push_back(ex);
    cyc();
    compare(name);
  endtask
  task automatic test_reset;
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    sb.push_back({4'd8, 4'd8, 2'b01, 1'b0, 1'b0, 1'b0});
    compare("idle_hold");
  endtask
  task automatic test_right_wall;
    do_reset();
    start_game();
    for (int i = 0; i < 7; i++) do_tick(2'b01, 2'b01, {4'(9 + i), 4'd8, 2'b01, 1'b1, 1'b1, 1'b0}, "move_right");
    do_tick(2'b01, 2'b01, {4'd15, 4'd8, 2'b01, 1'b0, 1'b0, 1'b1}, "right_wall");
    for (int i = 0; i < 6; i++) cyc();
    sb.push_back({4'd15, 4'd8, 2'b01, 1'b0, 1'b0, 1'b1});
    compare("dead_frozen");
  endtask
  task automatic test_reversal;
    do_reset();
    start_game();
    do_tick(2'b11, 2'b11, {4'd9, 4'd8, 2'b01, 1'b1, 1'b1, 1'b0}, "reversal_ignored");
    do_tick(2'b00, 2'b00, {4'd9, 4'd7, 2'b00, 1'b1, 1'b1, 1'b0}, "turn_up");
  endtask
  task automatic test_glitch;
    do_reset();
    start_game();
    do_tick(2'b01, 2'b10, {4'd9, 4'd8, 2'b01, 1'b1, 1'b1, 1'b0}, "mid_interval_glitch");
  endtask
  task automatic test_up_wall_restart;
    do_reset();
    start_game();
    for (int i = 0; i < 8; i++) do_tick(2'b00, 2'b00, {4'd8, 4'(7 - i), 2'b00, 1'b1, 1'b1, 1'b0}, "move_up");
    do_tick(2'b00, 2'b00, {4'd8, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1}, "top_wall");
    cyc();
    start_game();
    do_tick(2'b01, 2'b01, {4'd9, 4'd8, 2'b01, 1'b1, 1'b1, 1'b0}, "restart_first_move");
  endtask
  task automatic test_reset_mid;
    do_reset();
    start_game();
    dir = 2'b10;
    cyc();
    cyc();
    reset = 1'b1;
    start = 1'b1;
    cyc();
    reset = 1'b0;
    start = 1'b0;
    sb.push_back({4'd8, 4'd8, 2'b01, 1'b0, 1'b0, 1'b0});
    compare("reset_mid_run");
    cyc();
    sb.push_back({4'd8, 4'd8, 2'b01, 1'b0, 1'b0, 1'b0});
    compare("no_partial_tick");
    for (int i = 0; i < 4; i++) cyc();
    sb.push_back({4'd8, 4'd8, 2'b01, 1'b0, 1'b0, 1'b0});
    compare("idle_after_reset");
  endtask
  task automatic test_back_to_back;
    do_reset();
    start_game();
    do_tick(2'b10, 2'b00, {4'd8, 4'd9, 2'b10, 1'b1, 1'b1, 1'b0}, "turn_down");
    do_tick(2'b11, 2'b01, {4'd7, 4'd9, 2'b11, 1'b1, 1'b1, 1'b0}, "turn_left");
    do_tick(2'b01, 2'b01, {4'd6, 4'd9, 2'b11, 1'b1, 1'b1, 1'b0}, "left_reversal");
  endtask
  initial begin
    test_reset();
    test_right_wall();
    test_reversal();
    test_glitch();
    test_up_wall_restart();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snake_head_mover.md
# snake_head_mover

Consumes the 2-bit `dir` code produced by the keypad direction encoder and advances the snake head one cell per game tick on the 16×16 LED grid. Owns the tick counter, the current heading, the head coordinates and the run/dead game state. It rejects 180° reversals and detects wall collisions. Sits between the direction encoder and the snake body/display logic, which consume `head_x`, `head_y` and `step`.

## Interface
- `TICK_CYCLES`, default 12_500_000: clock cycles per game tick; benches override it to 4; legal range is ≥ 2.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `dir`  in  2  requested direction: 00 up, 01 right, 10 down, 11 left
- `start`  in  1  level; begins or restarts a game
- `head_x`  out  4  head column, 0 = leftmost
- `head_y`  out  4  head row, 0 = top
- `heading`  out  2  direction of travel, same encoding as `dir`
- `step`  out  1  one-cycle pulse, high in the cycle the new head position is first visible
- `alive`  out  1  high while in RUN
- `dead`  out  1  high while in DEAD

## Operation
- States: IDLE, RUN, DEAD. All outputs are registered.
- Reset values: state IDLE, `head_x`=8, `head_y`=8, `heading`=01, tick count 0, `step`=0, `alive`=0, `dead`=0.
- IDLE:
  - `start`=1 → RUN, tick count cleared to 0.
  - The head stays at reset values.
- RUN:
  - The tick counter counts 0..TICK_CYCLES−1 and wraps to 0.
  - At the edge where count = TICK_CYCLES−1 (the tick), `dir` is sampled.
  - Reversal check: if `dir` = `heading` ^ 2'b10, the request is a reversal and is ignored. Otherwise the new heading is `dir`.
  - The next cell is computed from the new heading: up y−1, down y+1, left x−1, right x+1.
  - If the next cell is inside 0..15 on both axes: update `head_x`/`head_y` and `heading`, and assert `step` for one cycle.
  - Wall cases: up at y=0, down at y=15, left at x=0, right at x=15. In any wall case the next state is DEAD. The head holds its last legal position, `heading` takes the new value, and `step` stays 0.
  - `dir` between ticks is ignored; only the value at the tick edge matters. The block does no debouncing or filtering.
  - `start` in RUN is ignored.
- DEAD:
  - The head and heading are frozen.
  - `start`=1 → RUN with head (8,8), `heading`=01, count 0. The first move occurs TICK_CYCLES cycles later.
- Coordinates never wrap; wrap-around is not a legal move.
- `alive` = (state == RUN) and `dead` = (state == DEAD), both registered with the state.

## Timing
- `start` sampled high at edge E0 (from IDLE or DEAD) → `alive`=1 from E0.
- Ticks occur at edges E0+TICK_CYCLES, E0+2·TICK_CYCLES, and so on.
- Latency from tick edge to visible head update and `step`: zero cycles. Both are registered on the tick edge.
- `step` is high exactly one cycle per legal move and is never high in IDLE or DEAD.
- Collision: `dead`=1 and `alive`=0 from the tick edge itself.
- `reset` dominates everything, including `start` in the same cycle, and takes effect at the next edge from any state mid-count. No partial tick is carried over.
- `dir` is not required to be known between ticks. X on `dir` outside tick edges must not corrupt any state.

## Test plan
- Reset, then `start` pulse with TICK_CYCLES=4 and `dir`=01 held → `step` pulses at E0+4, +8, … with `head_x` going 9, 10, … 15 (7 moves). The 8th tick gives `dead`=1, `alive`=0, head stays (15,8), no `step`.
- Heading 01, `dir`=11 at a tick → `heading` stays 01 and `head_x` increments. Then `dir`=00 at the next tick → `heading`=00 and `head_y` goes 8→7.
- `dir`=10 for a single mid-interval cycle, then back to 01 before the tick → no turn, `head_x` increments.
- Heading up from (8,8) → 8 legal moves to y=0. The 9th tick gives `dead`=1, and the head remains (8,0).
- `reset` asserted at tick count 2 in RUN, with `start`=1 in the same cycle → next cycle shows IDLE with all reset values, `step`=0 at the would-be tick.
- In DEAD, `start` pulse → head (8,8), `heading`=01, `alive`=1. First `step` occurs 4 cycles later with `head_x`=9.
